// File: rtl/bram_bist.sv
// bram_bist: write/readback self-test driver for the single-port block RAM (BRAM_BIST_INVERT_PASS_EN adds an inverted-data second pass).
// Latency: done pulses 2N+2 cycles after the accepted start (4N+3 with the inverted pass).
// Backpressure: none; the RAM is driven every cycle and start is ignored while busy.
module bram_bist #(
    parameter int abits  = 8,
    parameter int dbytes = 4,
    parameter int blen   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [blen-1:0]         seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [abits+1:0]        err_count,
    output logic [abits-1:0]        first_err_addr,
    output logic [dbytes-1:0]       ram_we,
    output logic [abits-1:0]        ram_addr,
    output logic [dbytes*blen-1:0]  ram_wdata,
    input  logic [dbytes*blen-1:0]  ram_rdata
);
    localparam int dbits = dbytes * blen;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [abits-1:0]   cnt, cnt_nx;
    logic [blen-1:0]    seed_q, seed_nx;
    logic               inv_q, inv_nx;
    logic               cmp_vld, cmp_vld_nx;
    logic [abits-1:0]   cmp_addr, cmp_addr_nx;
    logic               cmp_inv, cmp_inv_nx;
    logic               mism;

    logic               busy_nx, done_nx, pass_nx;
    logic [abits+1:0]   err_nx;
    logic [abits-1:0]   ferr_nx;
    logic [dbytes-1:0]  we_nx;
    logic [abits-1:0]   addr_nx;
    logic [dbits-1:0]   wdata_nx;

    // Byte i of the word is (a + seed + i) mod 2^blen, optionally inverted.
    function automatic logic [dbits-1:0] pattern(input logic [abits-1:0] a,
                                                 input logic [blen-1:0]  s,
                                                 input logic             inv);
        logic [blen-1:0]  ab;
        logic [dbits-1:0] w;
        ab = blen'(a);
        w  = '0;
        for (int i = 0; i < dbytes; i++)
            w[i*blen +: blen] = ab + s + blen'(i);
        return inv ? ~w : w;
    endfunction

    // Read data arrives one cycle after the address, so the compare uses the delayed address.
    assign mism = cmp_vld && (ram_rdata != pattern(cmp_addr, seed_q, cmp_inv));

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        seed_nx     = seed_q;
        inv_nx      = inv_q;
        cmp_vld_nx  = 1'b0;
        cmp_addr_nx = cnt;
        cmp_inv_nx  = inv_q;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        pass_nx     = pass;
        err_nx      = err_count;
        ferr_nx     = first_err_addr;
        we_nx       = '0;
        addr_nx     = '0;
        wdata_nx    = '0;

        if (mism) begin
            err_nx = err_count + 1'b1;
            if (err_count == '0)
                ferr_nx = cmp_addr;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WRITE;
                    cnt_nx   = '0;
                    seed_nx  = seed;
                    inv_nx   = 1'b0;
                    err_nx   = '0;
                    ferr_nx  = '0;
                    pass_nx  = 1'b0;
                    busy_nx  = 1'b1;
                    we_nx    = '1;
                    wdata_nx = pattern('0, seed, 1'b0);
                end
            end
            WRITE: begin
                busy_nx = 1'b1;
                if (cnt == '1) begin
                    state_nx = READ;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    we_nx    = '1;
                    addr_nx  = cnt + 1'b1;
                    wdata_nx = pattern(cnt + 1'b1, seed_q, inv_q);
                end
            end
            READ: begin
                busy_nx    = 1'b1;
                cmp_vld_nx = 1'b1;
                if (cnt == '1) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx  = cnt + 1'b1;
                    addr_nx = cnt + 1'b1;
                end
            end
            DRAIN: begin
`ifdef BRAM_BIST_INVERT_PASS_EN
                if (!inv_q) begin
                    state_nx = WRITE;
                    cnt_nx   = '0;
                    inv_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    we_nx    = '1;
                    wdata_nx = pattern('0, seed_q, 1'b1);
                end else begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    pass_nx  = (err_nx == '0);
                end
`else
                state_nx = DONE;
                done_nx  = 1'b1;
                pass_nx  = (err_nx == '0);
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            seed_q         <= '0;
            inv_q          <= 1'b0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            cmp_inv        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            ram_we         <= '0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            seed_q         <= seed_nx;
            inv_q          <= inv_nx;
            cmp_vld        <= cmp_vld_nx;
            cmp_addr       <= cmp_addr_nx;
            cmp_inv        <= cmp_inv_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            pass           <= pass_nx;
            err_count      <= err_nx;
            first_err_addr <= ferr_nx;
            ram_we         <= we_nx;
            ram_addr       <= addr_nx;
            ram_wdata      <= wdata_nx;
        end
    end

endmodule

// File: tb/tb_bram_bist.sv
// Bench for bram_bist: behavioural RAM with injectable read faults, reference model of pattern, timing and error tally.
module tb_bram_bist;
    localparam int AB = 4;
    localparam int DB = 4;
    localparam int BL = 8;
    localparam int N  = 1 << AB;
`ifdef BRAM_BIST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          busy, done, pass;
    logic [AB+1:0] err_count;
    logic [AB-1:0] first_err_addr;
    logic [DB-1:0] ram_we;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [N];
    logic [31:0]   rd_q;
    logic [AB-1:0] raddr_q;
    logic [N-1:0]  fault_mask = '0;
    logic          fault_flip = 1'b0;

    int total = 0;
    int bad = 0;

    bram_bist #(.abits(AB), .dbytes(DB), .blen(BL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, byte enables, 1-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < DB; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        rd_q    <= mem[ram_addr];
        raddr_q <= ram_addr;
    end

    assign ram_rdata = fault_mask[raddr_q] ? {rd_q[31:1], (fault_flip ? ~rd_q[0] : 1'b0)} : rd_q;

    function automatic logic [31:0] pat(input int a, input int sd, input bit inv);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            w = w | (32'((a + sd + i) % 256) << (8 * i));
        return inv ? ~w : w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_test(input logic [7:0] sd, input logic [N-1:0] fmask, input logic fflip,
                            input int x1, input int x2, input string tag);
        int exp_err, exp_first, exp_done, done_cnt, done_cyc, seq_bad, mem_bad;
        logic exp_pass, p_at;
        logic [AB+1:0] e_at;
        logic [AB-1:0] f_at;
        fault_mask = fmask;
        fault_flip = fflip;
        exp_err = 0;
        exp_first = 0;
        for (int p = 0; p < PASSES; p++)
            for (int a = 0; a < N; a++) begin
                logic [31:0] w;
                logic seen;
                w = pat(a, sd, p == 1);
                seen = fmask[a] ? (fflip ? ~w[0] : 1'b0) : w[0];
                if (seen != w[0]) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end
        exp_pass = (exp_err == 0);
        exp_done = PASSES * (2 * N + 1) + 1;

        done_cnt = 0; done_cyc = -1; seq_bad = 0;
        p_at = 1'bx; e_at = 'x; f_at = 'x;
        @(negedge clk);
        seed = sd;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= exp_done + 8; k++) begin
            int c, pidx;
            logic [DB-1:0] ewe;
            logic [AB-1:0] eaddr;
            @(negedge clk);
            start = (k == x1 || k == x2);
            pidx = (k - 1) / (2 * N + 1);
            c = k - pidx * (2 * N + 1);
            ewe = '0;
            eaddr = '0;
            if (k < exp_done && c <= N) begin
                ewe = '1;
                eaddr = AB'(c - 1);
                if (ram_wdata !== pat(c - 1, sd, pidx == 1)) seq_bad++;
            end else if (k < exp_done && c <= 2 * N)
                eaddr = AB'(c - N - 1);
            if (ram_we !== ewe || ram_addr !== eaddr) seq_bad++;
            if (busy !== (k < exp_done)) seq_bad++;
            if (k < exp_done && pass !== 1'b0) seq_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
                p_at = pass; e_at = err_count; f_at = first_err_addr;
            end
        end
        start = 1'b0;
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " seq_violations"}, seq_bad, 0);
        chk({tag, " pass"}, p_at, exp_pass);
        chk({tag, " err_count"}, e_at, exp_err);
        chk({tag, " first_err_addr"}, f_at, exp_first);
        chk({tag, " pass_held"}, pass, exp_pass);
        mem_bad = 0;
        for (int a = 0; a < N; a++)
            if (mem[a] !== pat(a, sd, PASSES == 2)) mem_bad++;
        chk({tag, " ram_contents"}, mem_bad, 0);
        fault_mask = '0;
    endtask

    initial begin
        logic [7:0] rs;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pass", pass, 0);
        chk("rst err_count", err_count, 0);
        chk("rst first_err_addr", first_err_addr, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_wdata", ram_wdata, 0);

        // start held while reset is asserted must not launch a test
        start = 1'b1;
        @(posedge clk);
        #1 chk("start_in_reset busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test(8'h00, '0, 1'b0, 0, 0, "good");
`ifdef BRAM_BIST_INVERT_PASS_EN
        chk("good word5", mem[5], 32'hF7F8F9FA);
`else
        chk("good word5", mem[5], 32'h08070605);
`endif
        run_test(8'hFF, '0, 1'b0, 0, 0, "wrap");
`ifndef BRAM_BIST_INVERT_PASS_EN
        chk("wrap word0", mem[0], 32'h020100FF);
        chk("wrap word15", mem[15], 32'h11100F0E);
`endif
        run_test(8'h00, 16'h0008, 1'b0, 0, 0, "fault3");
        chk("fault3 err_count direct", err_count, 1);
        run_test(8'h00, 16'h0208, 1'b0, 0, 0, "fault3_9");
        chk("fault3_9 first direct", first_err_addr, 3);
        run_test(8'h3C, '0, 1'b0, 5, 20, "start_busy");
        run_test(8'h00, 16'h0004, 1'b1, 0, 0, "stuck2");
        for (int r = 0; r < 4; r++) begin
            rs = 8'($urandom);
            run_test(rs, N'($urandom_range(0, 3) == 0 ? 0 : ($urandom & $urandom)),
                     1'($urandom), 0, 0, $sformatf("rand%0d", r));
        end

        // reset in the middle of the write phase
        @(negedge clk);
        seed = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("midrst we_before", ram_we, 4'hF);
        chk("midrst busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst ram_we", ram_we, 0);
        chk("midrst busy", busy, 0);
        chk("midrst status", {done, pass, err_count, first_err_addr}, 0);
        chk("midrst ram_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_test(8'h5A, '0, 1'b0, 0, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_bist.md
Name: bram_bist

Overview:
- Built-in self-test initiator for the team's single-port block RAM.
- Acts as the requester on the RAM's we/addr/wdata/rdata interface.
- Writes an address-derived pattern to every word, reads every word back with the RAM's 1-cycle read latency, and compares.
- Reports pass/fail, mismatch count and first failing address; sits between the RAM and SoC status/debug logic.

Parameters:
- abits, 8, RAM address bits; N = 2^abits words.
- dbytes, 4, bytes per RAM word.
- blen, 8, bits per byte.
- dbits (localparam), dbytes*blen, word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE.
- seed  in  blen  pattern seed; latched when start is accepted.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  last test had zero mismatches; held until next accepted start.
- err_count  out  abits+2  mismatching words in last test.
- first_err_addr  out  abits  address of first mismatch; 0 if none.
- ram_we  out  dbytes  per-byte write enable to RAM.
- ram_addr  out  abits  RAM address.
- ram_wdata  out  dbits  RAM write data.
- ram_rdata  in  dbits  RAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs are 0: busy, done, pass, err_count, first_err_addr, ram_we, ram_addr, ram_wdata.
- Pattern P(a): byte i of the word = (a + seed + i) mod 2^blen, where a is zero-extended or truncated to blen bits. Arithmetic wraps silently.
- All outputs are registered.
- IDLE:
  - start=1 -> WRITE next cycle. Latch seed; clear err_count, first_err_addr and pass; busy=1.
  - start=0 -> stay in IDLE.
- WRITE: ram_we all ones, ram_addr=a, ram_wdata=P(a), for a = 0..N-1 on consecutive cycles (N cycles). After a=N-1 -> READ.
- READ: ram_we=0, ram_addr=a for a = 0..N-1 (N cycles). Each address is delayed one cycle and compared to ram_rdata in the following cycle. After a=N-1 -> DRAIN.
- DRAIN: 1 cycle; compares the last word; ram_we=0.
- DONE:
  - 1 cycle: done=1, busy=0, pass=(err_count==0).
  - ram_addr returns to 0 and stays 0 in IDLE.
  - -> IDLE.
- Timing: start sampled on edge 0 -> busy high during cycles 1..2N+1, done high in cycle 2N+2. abits=4 gives done at cycle 34.
- Mismatch (any bit differs):
  - err_count increments.
  - If it is the first mismatch, first_err_addr captures the delayed address.
  - err_count cannot overflow: its maximum value 2N fits in abits+2 bits.
- start is ignored while busy; it is not queued.
- start and rst_n asserted together: reset wins.
- Reset mid-test: ram_we drops immediately; the partial result is discarded; a new start after reset runs a full test.
- ram_we is never asserted outside WRITE.

Optional Feature:
- Macro BRAM_BIST_INVERT_PASS_EN.
- Defined:
  - After DRAIN, run a second WRITE/READ/DRAIN sequence using ~P(a) (bitwise inverse).
  - Errors accumulate across both passes; first_err_addr is the first mismatch in either pass.
  - done arrives in cycle 4N+3; abits=4 gives cycle 67.
  - Final RAM contents are ~P(a).
- Undefined: single pass only, as above; final RAM contents are P(a).

Test Plan:
- Good RAM: abits=4, dbytes=4, blen=8, seed=0x00, bench instantiates the team's block RAM; pulse start -> busy cycles 1..33, done pulse at cycle 34, pass=1, err_count=0, RAM word 5 = 0x08070605.
- Seed wrap: seed=0xFF -> RAM word 0 = 0x020100FF, word 15 = 0x1110_0F0E + 0xFF-adjusted bytes (0x11100F0E), pass=1.
- Injected fault: bench forces ram_rdata bit 0 to 0 whenever the delayed address is 3 -> err_count=1, first_err_addr=3, pass=0; a second fault at address 9 -> err_count=2, first_err_addr still 3.
- Start while busy: extra start pulses at cycles 5 and 20 -> exactly one done pulse at cycle 34, no restart.
- Reset mid-write: rst_n low during cycle 5 -> ram_we=0 and busy=0 without waiting for a clock edge, all status outputs 0; a new start completes normally with pass=1.
- BRAM_BIST_INVERT_PASS_EN defined, abits=4, seed=0 -> done at cycle 67, pass=1, RAM word 5 = 0xF7F8F9FA; stuck bit fault at address 2 in both passes -> err_count=2.
